// File: rtl/lookup_arbiter.sv
// lookup_arbiter
//   Round-robin arbiter that shares one MAC learning/lookup stage between four
//   ingress ports. A granted port's MAC pair is presented to the learning stage
//   with a one-cycle ml_en strobe. The stage's answer (or a timeout) is then
//   returned to that port as a one-cycle resp_valid pulse. Only one lookup is
//   in flight at any time.
//
// Ports
//   clk, rst      : clock (posedge) and synchronous active-high reset
//   req_valid     : per-port request, held until that port's resp_valid
//   req_src_mac   : port i source MAC at [48*i +: 48]
//   req_dst_mac   : port i destination MAC at [48*i +: 48]
//   resp_valid    : one-hot, one-cycle completion pulse
//   resp_port     : forwarding result (3'b110 whenever resp_valid is zero)
//   ml_en         : one-cycle lookup strobe to the learning stage
//   ml_src_mac    : source MAC held for the duration of the lookup
//   ml_dst_mac    : destination MAC held for the duration of the lookup
//   ml_src_port   : {1'b0, granted index}
//   ml_done       : learning-stage result strobe
//   ml_dst_port   : learning-stage result, valid with ml_done
//   ml_busy       : learning stage cannot accept a new lookup
//   timeout_cnt   : saturating count of lookups that timed out

module lookup_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NPORTS         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORTS-1:0]     req_valid,
  input  logic [48*NPORTS-1:0]  req_src_mac,
  input  logic [48*NPORTS-1:0]  req_dst_mac,
  output logic [NPORTS-1:0]     resp_valid,
  output logic [2:0]            resp_port,
  output logic                  ml_en,
  output logic [47:0]           ml_src_mac,
  output logic [47:0]           ml_dst_mac,
  output logic [2:0]            ml_src_port,
  input  logic                  ml_done,
  input  logic [2:0]            ml_dst_port,
  input  logic                  ml_busy,
  output logic [15:0]           timeout_cnt
);

  // Timer only has to count up to TIMEOUT_CYCLES-1.
  localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0]  PORT_DROP    = 3'b101;
  localparam logic [2:0]  PORT_TIMEOUT = 3'b110;
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_r;
  logic [1:0]     rr_ptr_r;
  logic [1:0]     idx_r;
  logic [TW-1:0]  timer_r;

  logic           grant_found_s;
  logic [1:0]     grant_idx_s;

  // Round-robin pick: the first requesting port at or after ptr, wrapping mod 4.
  // The loop runs from the farthest offset down so that the nearest hit is the
  // one left in place at the end. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] cand;
    pick = 3'b000;
    for (int off = 3; off >= 0; off--) begin
      cand = ptr + off[1:0];
      if (req[cand]) begin
        pick = {1'b1, cand};
      end
    end
    return pick;
  endfunction

  // A lookup that would send the frame back out of its own ingress port is
  // turned into a drop. Every other result, flood included, passes unchanged.
  function automatic logic [2:0] lookup_result(input logic [2:0] dst, input logic [2:0] src);
    logic [2:0] res;
    if (dst == src) begin
      res = PORT_DROP;
    end else begin
      res = dst;
    end
    return res;
  endfunction

  // One-hot completion vector for a granted index.
  function automatic logic [3:0] port_onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction

  // Arbitration decision for the current request vector.
  always_comb begin
    logic [2:0] pick_s;
    pick_s        = rr_pick(req_valid[3:0], rr_ptr_r);
    grant_found_s = pick_s[2];
    grant_idx_s   = pick_s[1:0];
  end

  // Arbiter FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 2'd0;
      idx_r       <= 2'd0;
      timer_r     <= '0;
      timeout_cnt <= 16'd0;
      resp_valid  <= '0;
      resp_port   <= PORT_TIMEOUT;
      ml_en       <= 1'b0;
      ml_src_mac  <= 48'd0;
      ml_dst_mac  <= 48'd0;
      ml_src_port <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid <= '0;
          resp_port  <= PORT_TIMEOUT;
          if (grant_found_s && !ml_busy) begin
            // ml_en rises with the grant so that it is high for the whole ISSUE cycle.
            idx_r       <= grant_idx_s;
            ml_src_mac  <= req_src_mac[48*grant_idx_s +: 48];
            ml_dst_mac  <= req_dst_mac[48*grant_idx_s +: 48];
            ml_src_port <= {1'b0, grant_idx_s};
            ml_en       <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            ml_en   <= 1'b0;
            state_r <= IDLE;
          end
        end

        ISSUE: begin
          ml_en   <= 1'b0;
          timer_r <= '0;
          state_r <= WAIT;
        end

        WAIT: begin
          ml_en <= 1'b0;
          if (ml_done) begin
            // A real answer wins over a timeout that expires in the same cycle.
            resp_port  <= lookup_result(ml_dst_port, ml_src_port);
            resp_valid <= port_onehot(idx_r);
            state_r    <= RESP;
          end else if (timer_r == TIMER_LAST) begin
            resp_port  <= PORT_TIMEOUT;
            resp_valid <= port_onehot(idx_r);
            if (timeout_cnt != CNT_MAX) begin
              timeout_cnt <= timeout_cnt + 16'd1;
            end else begin
              timeout_cnt <= CNT_MAX;
            end
            state_r <= RESP;
          end else begin
            timer_r <= timer_r + TW'(1);
            state_r <= WAIT;
          end
        end

        RESP: begin
          // The pulse is visible during this cycle. Close it out and move the
          // round-robin pointer past the port that was just served.
          resp_valid <= '0;
          resp_port  <= PORT_TIMEOUT;
          ml_en      <= 1'b0;
          rr_ptr_r   <= idx_r + 2'd1;
          state_r    <= IDLE;
        end

        default: begin
          resp_valid <= '0;
          resp_port  <= PORT_TIMEOUT;
          ml_en      <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lookup_arbiter.md
LOOKUP_ARBITER -- requirements
Module: lookup_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max cycles to wait for ml_done after ml_en.
REQ-002 SHALL have parameter NPORTS, default 4: number of requesting ingress ports; fixed at 4 in this revision.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  4  per-port lookup request; held high until that port's resp_valid.
REQ-006 SHALL have port req_src_mac  input  192  port i source MAC at [48*i +: 48]; stable while req_valid[i].
REQ-007 SHALL have port req_dst_mac  input  192  port i destination MAC at [48*i +: 48]; stable while req_valid[i].
REQ-008 SHALL have port resp_valid  output  4  one-cycle one-hot pulse completing port i's request.
REQ-009 SHALL have port resp_port  output  3  forwarding result; valid when any resp_valid bit is high.
REQ-010 SHALL have port ml_en  output  1  one-cycle lookup strobe to the MAC learning stage.
REQ-011 SHALL have port ml_src_mac  output  48  source MAC to the learning stage.
REQ-012 SHALL have port ml_dst_mac  output  48  destination MAC to the learning stage.
REQ-013 SHALL have port ml_src_port  output  3  {1'b0, granted index}.
REQ-014 SHALL have port ml_done  input  1  learning-stage result strobe.
REQ-015 SHALL have port ml_dst_port  input  3  learning-stage result; sampled only when ml_done.
REQ-016 SHALL have port ml_busy  input  1  learning-stage busy.
REQ-017 SHALL have port timeout_cnt  output  16  saturating count of timed-out lookups.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE SHALL grant only when any req_valid is high and ml_busy is low; otherwise remain IDLE.
REQ-020 Grant SHALL be round-robin: first set req_valid bit at or after rr_ptr, searching upward mod 4.
REQ-021 On grant, SHALL latch the index and that port's MACs into ml_src_mac/ml_dst_mac/ml_src_port, then go to ISSUE.
REQ-022 ml_src_mac, ml_dst_mac, ml_src_port SHALL hold constant from grant until return to IDLE.
REQ-023 ISSUE SHALL assert ml_en for exactly one cycle, clear the wait timer and go to WAIT.
REQ-024 WAIT, ml_done high: capture result, go to RESP.
REQ-025 Captured result SHALL be 3'b101 (drop) when ml_dst_port equals ml_src_port; otherwise ml_dst_port unchanged (3'b100 flood passes through).
REQ-026 WAIT, ml_done low: increment timer; on reaching TIMEOUT_CYCLES-1, capture 3'b110, increment timeout_cnt, go to RESP.
REQ-027 ml_done and timeout in the same cycle: ml_done SHALL win; timeout_cnt unchanged.
REQ-028 timeout_cnt SHALL saturate at 16'hFFFF.
REQ-029 RESP SHALL pulse resp_valid[idx] for one cycle with resp_port = captured result, set rr_ptr = (idx+1) mod 4, go to IDLE.
REQ-030 Latency grant->ml_en SHALL be 1 cycle; ml_done->resp_valid SHALL be 1 cycle.
REQ-031 ml_done outside WAIT SHALL be ignored.
REQ-032 req_valid dropped before its response SHALL NOT abort the transaction; the response is still issued.
REQ-033 At most one request SHALL be outstanding; the next grant occurs no earlier than the cycle after RESP.
REQ-034 resp_port SHALL read 3'b110 whenever resp_valid is all zero.

Reset
REQ-035 rst SHALL force state IDLE, rr_ptr 0, timer 0, timeout_cnt 0.
REQ-036 rst SHALL force resp_valid 0, ml_en 0, resp_port 3'b110, ml_src_mac 0, ml_dst_mac 0, ml_src_port 0.
REQ-037 rst mid-transaction SHALL abandon the request with no resp_valid; a later ml_done is ignored.

Verification
REQ-038 Single request: req_valid=4'b0010, dst MAC learned on port 3, ml_done 3 cycles after ml_en -> ml_src_port=3'b001, resp_valid=4'b0010, resp_port=3'b011.
REQ-039 Fairness: req_valid=4'b1111 held, each dropped after its response -> grant order 0,1,2,3, then 0 again.
REQ-040 Busy gating: ml_busy=1 for 10 cycles with req_valid=4'b0001 -> ml_en stays 0 until the cycle after ml_busy falls.
REQ-041 Timeout: ml_done never asserted -> resp_port=3'b110 at TIMEOUT_CYCLES+1 cycles after ml_en, timeout_cnt=1.
REQ-042 Hairpin: port 2 request, ml_dst_port=3'b010 -> resp_port=3'b101.
REQ-043 Reset in WAIT, then ml_done pulse -> no resp_valid, all outputs at reset values.
